// File: rtl/mux_pkg.sv
// Shared types for the 4-channel round-robin gather mux.
package mux_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_st_t;
endpackage

// File: rtl/mux_4to1_rr_arb.sv
// Combinational 4-way round-robin arbiter: first requester at or after ptr wins.
module rr_arb_4
  import mux_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            ptr,
  output sel_t            gnt,
  output logic            gnt_vld
);

  sel_t idx;

  // Scan from the farthest offset down so the closest requester to ptr is written last.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = ptr + sel_t'(k);
      if (req[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_4to1_rr.sv
// Registered 4:1 round-robin gather mux; 1 cycle from accept to out_valid, one word per cycle.
// A stalled output (out_valid && !out_ready) deasserts all in_ready and freezes the pointer.
module mux_4to1_rr
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output sel_t                   out_sel,
  input  logic                   out_ready
);

  sel_t     ptr;
  sel_t     gnt;
  logic     gnt_vld;
  logic     slot_free;
  logic     accept;
  hold_st_t state;
  hold_st_t state_nxt;

  rr_arb_4 u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  assign slot_free = (state == ST_EMPTY) || out_ready;
  assign accept    = slot_free && gnt_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // rst_n gates in_ready so no producer sees a handshake while the block is held in reset.
  always_comb begin
    out_valid = (state == ST_FULL);
    in_ready  = '0;
    if (accept && rst_n) begin
      in_ready[gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else if (accept) begin
      out_data <= in_data[int'(gnt)*DATA_W +: DATA_W];
      out_sel  <= gnt;
      ptr      <= gnt + sel_t'(1);
    end
  end

endmodule

// File: tb/tb_mux_4to1_rr.sv
// Bench for mux_4to1_rr: directed scenarios plus random traffic against a behavioural model.
module tb_mux_4to1_rr;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: held word, its source and the round-robin start channel.
  bit        m_valid;
  logic [DW-1:0] m_data;
  int        m_sel;
  int        m_ptr;

  always #5 clk = ~clk;

  mux_4to1_rr #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  function automatic int model_gnt(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    g = model_gnt(in_valid, m_ptr);
    if (g >= 0 && (!m_valid || out_ready)) return 4'b0001 << g;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // One rising edge with the current inputs; model updated; returns at edge + 1.
  task automatic step(output int acc_ch);
    int g;
    logic [DW-1:0] d;
    g = model_gnt(in_valid, m_ptr);
    acc_ch = -1;
    d = '0;
    if (g >= 0 && (!m_valid || out_ready)) begin
      acc_ch = g;
      d = in_data[g*DW +: DW];
    end
    @(posedge clk);
    if (acc_ch >= 0) begin
      m_valid = 1'b1;
      m_data  = d;
      m_sel   = acc_ch;
      m_ptr   = (acc_ch + 1) % 4;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    int ch;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0 || in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d: got valid=%b data=%h sel=%0d rdy=%b, want 0/00/0/0000",
                 c, out_valid, out_data, out_sel, in_ready);
      end
      step(ch);
    end
  endtask

  task automatic test_single();
    int ch;
    in_valid  = 4'b0100;
    in_data   = '0;
    in_data[2*DW +: DW] = 8'hA5;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0100", in_ready);
    end
    step(ch);
    in_valid = 4'b0000;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL single_out: got valid=%b data=%h sel=%0d want 1/a5/2", out_valid, out_data, out_sel);
    end
    // ptr now 3: with ch0 and ch3 requesting, ch3 must win.
    in_valid = 4'b1001;
    in_data[0 +: DW]    = 8'h30;
    in_data[3*DW +: DW] = 8'h33;
    #1;
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_ptr3: got %b want 1000", in_ready);
    end
    in_valid = 4'b0000;
    step(ch);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_all_rr();
    int ch;
    apply_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*DW +: DW] = 8'h10 + 8'(i);
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (in_ready !== (4'b0001 << (i % 4))) begin
        n_fail++;
        $display("FAIL rr_ready i=%0d: got %b want %b", i, in_ready, 4'b0001 << (i % 4));
      end
      step(ch);
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== 8'h10 + 8'(i % 4)) begin
        n_fail++;
        $display("FAIL rr_out i=%0d: got valid=%b sel=%0d data=%h want 1/%0d/%h",
                 i, out_valid, out_sel, out_data, i % 4, 8'h10 + 8'(i % 4));
      end
    end
  endtask

  task automatic test_stall();
    int ch;
    apply_reset();
    in_valid = 4'b1010;
    in_data[1*DW +: DW] = 8'h51;
    in_data[3*DW +: DW] = 8'h53;
    out_ready = 1'b1;
    step(ch);
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h51) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d: got rdy=%b valid=%b sel=%0d data=%h want 0000/1/1/51",
                 c, in_ready, out_valid, out_sel, out_data);
      end
      step(ch);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b want 1000", in_ready);
    end
    step(ch);
    in_valid = 4'b0000;
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 8'h53) begin
      n_fail++;
      $display("FAIL stall_next: got valid=%b sel=%0d data=%h want 1/3/53", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_async_reset();
    int ch;
    apply_reset();
    in_valid = 4'b0010;
    in_data[1*DW +: DW] = 8'h77;
    out_ready = 1'b1;
    step(ch);
    out_ready = 1'b0;
    in_valid  = 4'b1001;
    in_data[0 +: DW]    = 8'hC0;
    in_data[3*DW +: DW] = 8'hC3;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b rdy=%b want 0/0000", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_ptr0: got %b want 0001", in_ready);
    end
    step(ch);
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hC0) begin
      n_fail++;
      $display("FAIL async_first: got valid=%b sel=%0d data=%h want 1/0/c0", out_valid, out_sel, out_data);
    end
    in_valid = 4'b0000;
    step(ch);
  endtask

  task automatic test_random();
    bit            pend [4];
    logic [DW-1:0] pdat [4];
    int            waits [4];
    int            sb_ch [$];
    logic [DW-1:0] sb_dat [$];
    logic [3:0]    exp_rdy;
    logic [3:0]    demux;
    int            ch;
    int            e_ch;
    logic [DW-1:0] e_dat;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      pend[i]  = 1'b0;
      pdat[i]  = '0;
      waits[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pdat[i] = DW'($urandom);
        end
        in_valid[i] = pend[i];
        in_data[i*DW +: DW] = pdat[i];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = model_ready();
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, exp_rdy);
      end
      // Loopback through an ideal 1:4 demux driven by out_valid/out_sel.
      if (out_valid && out_ready) begin
        demux = 4'b0001 << out_sel;
        e_ch  = -1;
        e_dat = '0;
        if (sb_ch.size() > 0) begin
          e_ch  = sb_ch.pop_front();
          e_dat = sb_dat.pop_front();
        end
        n_checks++;
        if (e_ch < 0 || demux !== (4'b0001 << e_ch) || out_data !== e_dat) begin
          n_fail++;
          $display("FAIL loopback c=%0d: got demux=%b data=%h want ch=%0d data=%h",
                   c, demux, out_data, e_ch, e_dat);
        end
      end
      if (|in_ready) begin
        for (int i = 0; i < 4; i++) begin
          if (in_ready[i]) begin
            n_checks++;
            if (waits[i] > 3) begin
              n_fail++;
              $display("FAIL fairness ch=%0d: got %0d prior accepts want <=3", i, waits[i]);
            end
            waits[i] = 0;
          end else if (pend[i]) begin
            waits[i]++;
          end
        end
      end
      step(ch);
      if (ch >= 0) begin
        sb_ch.push_back(ch);
        sb_dat.push_back(pdat[ch]);
        pend[ch] = 1'b0;
      end
      n_checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== 2'(m_sel)))) begin
        n_fail++;
        $display("FAIL rand_out c=%0d: got valid=%b data=%h sel=%0d want %b/%h/%0d",
                 c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_all_rr();
    test_stall();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
